scan_cfg_loader: RTL and testbench

- Upstream configuration master for the CLB scan chain.
- Accepts configuration words from a host over a valid/ready stream and serialises them LSB-first onto the chain's scan_in.
- Generates scan_clk and scan_en from the single system clock.
- Captures the bits returning on the chain's scan_out as readback words, so a second load returns the contents of the first.

---
 rtl/scan_cfg_loader.sv | 202 ++++++++++++++++++++
 tb/tb_scan_cfg_loader.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/scan_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module   : scan_cfg_loader
// Purpose  : Upstream configuration master for the CLB scan chain. Takes
//            configuration words from a host over a valid/ready stream,
//            shifts them LSB-first onto scan_in using a registered scan_clk
//            derived from clk, and packs the bits returning on scan_out into
//            readback words (so a second load reads back the first).
// Ports    : clk, rst                 - system clock, sync active-high reset
//            start                    - begin a load (IDLE/DONE only)
//            cfg_data/valid/ready     - host configuration word stream
//            scan_clk/scan_en/scan_in - drive to the chain head
//            scan_out                 - chain tail
//            rb_data/rb_valid         - readback words, one pulse per word
//            busy, done               - status
// Revision : 1.0 - initial release
// ============================================================================
module scan_cfg_loader #(
    parameter int CHAIN_LEN = 29,
    parameter int WORD_W    = 8,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              scan_clk,
    output logic              scan_en,
    output logic              scan_in,
    input  logic              scan_out,
    output logic [WORD_W-1:0] rb_data,
    output logic              rb_valid,
    output logic              busy,
    output logic              done
);

    localparam int c_NWORDS_I = (CHAIN_LEN + WORD_W - 1) / WORD_W;
    localparam int c_BIW_W    = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    localparam logic [CNT_W-1:0]   c_NWORDS       = CNT_W'(c_NWORDS_I);
    localparam logic [CNT_W-1:0]   c_LAST_BIT     = CNT_W'(CHAIN_LEN - 1);
    localparam logic [c_BIW_W-1:0] c_LAST_IN_WORD = c_BIW_W'(WORD_W - 1);

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_LOAD    = 3'd1;
    localparam logic [2:0] c_ST_SHIFT_A = 3'd2;
    localparam logic [2:0] c_ST_SHIFT_B = 3'd3;
    localparam logic [2:0] c_ST_FINISH  = 3'd4;
    localparam logic [2:0] c_ST_DONE    = 3'd5;

    logic [2:0]         r_state;
    logic [WORD_W-1:0]  r_hold;
    logic               r_hold_full;
    logic [WORD_W-1:0]  r_shift;      // bits of the current word still to go
    logic [CNT_W-1:0]   r_bit_cnt;    // bits completed in this load
    logic [CNT_W-1:0]   r_word_cnt;   // words accepted in this load
    logic [c_BIW_W-1:0] r_biw;        // index of current bit within its word
    logic [WORD_W-1:0]  r_rb_word;    // readback word under assembly

    logic               r_scan_clk;
    logic               r_scan_en;
    logic               r_scan_in;
    logic [WORD_W-1:0]  r_rb_data;
    logic               r_rb_valid;
    logic               r_busy;
    logic               r_done;

    logic               w_cfg_ready;
    logic               w_accept;
    logic [WORD_W-1:0]  w_load_word;
    logic [WORD_W-1:0]  w_sample;

    assign w_cfg_ready = r_busy & ~r_hold_full & (r_word_cnt < c_NWORDS);
    assign w_accept    = cfg_valid & w_cfg_ready;
    // In LOAD a waiting held word has priority; otherwise the word arriving
    // this cycle goes straight into the shift register.
    assign w_load_word = r_hold_full ? r_hold : cfg_data;
    assign w_sample    = {{(WORD_W-1){1'b0}}, scan_out} << r_biw;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_word_cnt  <= '0;
            r_biw       <= '0;
            r_rb_word   <= '0;
            r_scan_clk  <= 1'b0;
            r_scan_en   <= 1'b0;
            r_scan_in   <= 1'b0;
            r_rb_data   <= '0;
            r_rb_valid  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_rb_valid <= 1'b0;
            if (w_accept) begin
                r_word_cnt <= r_word_cnt + CNT_W'(1);
            end

            case (r_state)
                c_ST_IDLE, c_ST_DONE: begin
                    if (start) begin
                        r_state     <= c_ST_LOAD;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                        r_bit_cnt   <= '0;
                        r_word_cnt  <= '0;
                        r_biw       <= '0;
                        r_hold_full <= 1'b0;
                        r_rb_word   <= '0;
                    end
                end

                // Entered at the start of a load (scan_en still 0) or on a
                // host stall (scan_en held 1, scan_clk 0: no extra edges).
                c_ST_LOAD: begin
                    if (r_hold_full || w_accept) begin
                        r_shift     <= w_load_word >> 1;
                        r_scan_in   <= w_load_word[0];
                        r_scan_en   <= 1'b1;
                        r_scan_clk  <= 1'b0;
                        r_biw       <= '0;
                        r_hold_full <= 1'b0;
                        r_state     <= c_ST_SHIFT_A;
                    end
                end

                // Phase A: data set up. The edge leaving it samples the
                // chain tail before the chain shifts.
                c_ST_SHIFT_A: begin
                    if (w_accept) begin
                        r_hold      <= cfg_data;
                        r_hold_full <= 1'b1;
                    end
                    r_scan_clk       <= 1'b1;
                    r_state          <= c_ST_SHIFT_B;
                    r_rb_word[r_biw] <= scan_out;
                    if (r_biw == c_LAST_IN_WORD || r_bit_cnt == c_LAST_BIT) begin
                        r_rb_data  <= r_rb_word | w_sample;
                        r_rb_valid <= 1'b1;
                        r_rb_word  <= '0;
                    end
                end

                // Phase B: scan_clk high; the chain captures on its rise.
                c_ST_SHIFT_B: begin
                    if (w_accept) begin
                        r_hold      <= cfg_data;
                        r_hold_full <= 1'b1;
                    end
                    r_scan_clk <= 1'b0;
                    r_bit_cnt  <= r_bit_cnt + CNT_W'(1);
                    if (r_bit_cnt == c_LAST_BIT) begin
                        // Any unused upper bits of the final word are dropped.
                        r_scan_en <= 1'b0;
                        r_scan_in <= 1'b0;
                        r_state   <= c_ST_FINISH;
                    end else if (r_biw != c_LAST_IN_WORD) begin
                        r_scan_in <= r_shift[0];
                        r_shift   <= r_shift >> 1;
                        r_biw     <= r_biw + c_BIW_W'(1);
                        r_state   <= c_ST_SHIFT_A;
                    end else if (r_hold_full) begin
                        r_scan_in   <= r_hold[0];
                        r_shift     <= r_hold >> 1;
                        r_hold_full <= 1'b0;
                        r_biw       <= '0;
                        r_state     <= c_ST_SHIFT_A;
                    end else begin
                        r_state <= c_ST_LOAD;
                    end
                end

                c_ST_FINISH: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= c_ST_DONE;
                end

                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign cfg_ready = w_cfg_ready;
    assign scan_clk  = r_scan_clk;
    assign scan_en   = r_scan_en;
    assign scan_in   = r_scan_in;
    assign rb_data   = r_rb_data;
    assign rb_valid  = r_rb_valid;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_scan_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_scan_cfg_loader
// Purpose  : Directed self-checking bench for scan_cfg_loader with a 29-bit
//            shift-register model of the scan chain on the far side.
// Revision : 1.0 - initial release
// ============================================================================
module tb_scan_cfg_loader;

    localparam int c_CHAIN_LEN = 29;
    localparam int c_WORD_W    = 8;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic [c_WORD_W-1:0] cfg_data;
    logic                cfg_valid;
    logic                cfg_ready;
    logic                scan_clk;
    logic                scan_en;
    logic                scan_in;
    logic                scan_out;
    logic [c_WORD_W-1:0] rb_data;
    logic                rb_valid;
    logic                busy;
    logic                done;

    scan_cfg_loader #(
        .CHAIN_LEN (c_CHAIN_LEN),
        .WORD_W    (c_WORD_W),
        .CNT_W     (16)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cfg_data  (cfg_data),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .scan_clk  (scan_clk),
        .scan_en   (scan_en),
        .scan_in   (scan_in),
        .scan_out  (scan_out),
        .rb_data   (rb_data),
        .rb_valid  (rb_valid),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Chain model and observers, all evaluated mid-cycle (negedge).
    logic [c_CHAIN_LEN-1:0] chain = '0;
    logic                   prev_sclk = 1'b0;
    int                     edge_cnt = 0;
    int                     en_cyc = 0;
    logic                   edge_bits[$];
    logic [c_WORD_W-1:0]    rb_q[$];

    assign scan_out = chain[c_CHAIN_LEN-1];

    always @(negedge clk) begin
        if (scan_clk === 1'b1 && prev_sclk === 1'b0) begin
            edge_cnt = edge_cnt + 1;
            edge_bits.push_back(scan_in);
            chain = {chain[c_CHAIN_LEN-2:0], scan_in};
        end
        prev_sclk = scan_clk;
        if (scan_en === 1'b1) en_cyc = en_cyc + 1;
        if (rb_valid === 1'b1) rb_q.push_back(rb_data);
    end

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send_word(input logic [c_WORD_W-1:0] w);
        bit got;
        got = 1'b0;
        cfg_data  = w;
        cfg_valid = 1'b1;
        for (int n = 0; n < 300 && !got; n++) begin
            if (cfg_ready === 1'b1) got = 1'b1;
            tick();
        end
        check("accept", 64'(got), 64'd1);
    endtask

    task automatic wait_done();
        for (int n = 0; n < 300 && done !== 1'b1; n++) tick();
        check("done_reached", 64'(done), 64'd1);
    endtask

    function automatic logic [c_CHAIN_LEN-1:0] bits_since(input int base);
        logic [c_CHAIN_LEN-1:0] v;
        v = '0;
        for (int i = 0; i < c_CHAIN_LEN; i++)
            if (base + i < edge_bits.size()) v[i] = edge_bits[base + i];
        return v;
    endfunction

    function automatic logic [14:0] outs();
        return {scan_clk, scan_en, scan_in, cfg_ready, rb_valid, rb_data, busy, done};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int b_e, b_en, b_rb, extra, e0;
        rst = 1'b1; start = 1'b0; cfg_valid = 1'b0; cfg_data = '0;

        // Reset held two cycles in idle.
        tick(); tick();
        check("reset_outs", 64'(outs()), 64'd0);
        rst = 1'b0;
        cfg_valid = 1'b1; cfg_data = 8'h99;
        tick();
        check("idle_not_ready", 64'(cfg_ready), 64'd0);
        check("idle_not_busy", 64'(busy), 64'd0);
        cfg_valid = 1'b0;

        // Full load, valid held high, fifth word offered but refused.
        b_e = edge_cnt; b_en = en_cyc; b_rb = rb_q.size();
        start = 1'b1; tick(); start = 1'b0;
        check("busy_after_start", 64'(busy), 64'd1);
        send_word(8'hA5); send_word(8'h3C); send_word(8'hF0); send_word(8'h1F);
        cfg_data = 8'hEE;
        extra = 0;
        for (int n = 0; n < 300 && done !== 1'b1; n++) begin
            if (cfg_ready === 1'b1) extra++;
            tick();
        end
        cfg_valid = 1'b0;
        check("load1_done", 64'(done), 64'd1);
        check("load1_not_busy", 64'(busy), 64'd0);
        check("load1_fifth_refused", 64'(extra), 64'd0);
        check("load1_edges", 64'(edge_cnt - b_e), 64'd29);
        check("load1_bits", 64'(bits_since(b_e)), 64'h1FF03CA5);
        check("load1_shift_cycles", 64'(en_cyc - b_en), 64'd58);
        check("load1_rb_pulses", 64'(rb_q.size() - b_rb), 64'd4);

        // Loopback: start from DONE, load zeros, read back the first load.
        b_e = edge_cnt; b_rb = rb_q.size();
        start = 1'b1; tick(); start = 1'b0;
        check("done_drops", 64'(done), 64'd0);
        check("busy_again", 64'(busy), 64'd1);
        for (int i = 0; i < 4; i++) send_word(8'h00);
        cfg_valid = 1'b0;
        wait_done();
        check("load2_edges", 64'(edge_cnt - b_e), 64'd29);
        check("load2_rb_pulses", 64'(rb_q.size() - b_rb), 64'd4);
        check("rb_word0", 64'(rb_q[b_rb + 0]), 64'hA5);
        check("rb_word1", 64'(rb_q[b_rb + 1]), 64'h3C);
        check("rb_word2", 64'(rb_q[b_rb + 2]), 64'hF0);
        check("rb_word3", 64'(rb_q[b_rb + 3]), 64'h1F);
        check("chain_zero", 64'(chain), 64'd0);

        // Host stall after the first word, with a stray start during SHIFT.
        b_e = edge_cnt;
        start = 1'b1; tick(); start = 1'b0;
        send_word(8'h5A);
        cfg_valid = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        check("start_ignored_busy", 64'(busy), 64'd1);
        for (int i = 0; i < 24; i++) tick();
        check("stall_edges", 64'(edge_cnt - b_e), 64'd8);
        check("stall_sclk_low", 64'(scan_clk), 64'd0);
        check("stall_en_high", 64'(scan_en), 64'd1);
        send_word(8'h81); send_word(8'h7E); send_word(8'h0B);
        cfg_valid = 1'b0;
        wait_done();
        check("stall_total_edges", 64'(edge_cnt - b_e), 64'd29);
        check("stall_bit8", 64'(edge_bits[b_e + 8]), 64'd1);
        check("stall_bits", 64'(bits_since(b_e)), 64'h0B7E815A);

        // Reset after 12 edges, then a clean restart.
        b_e = edge_cnt;
        start = 1'b1; tick(); start = 1'b0;
        send_word(8'hC3); send_word(8'h96);
        cfg_valid = 1'b0;
        for (int n = 0; n < 200 && (edge_cnt - b_e) < 12; n++) tick();
        check("mid_edges", 64'(edge_cnt - b_e), 64'd12);
        rst = 1'b1; tick(); rst = 1'b0;
        check("midreset_outs", 64'(outs()), 64'd0);
        e0 = edge_cnt;
        for (int i = 0; i < 4; i++) tick();
        check("no_edge_after_reset", 64'(edge_cnt - e0), 64'd0);
        b_e = edge_cnt;
        start = 1'b1; tick(); start = 1'b0;
        send_word(8'h11); send_word(8'h22); send_word(8'h33); send_word(8'h44);
        cfg_valid = 1'b0;
        wait_done();
        check("restart_edges", 64'(edge_cnt - b_e), 64'd29);
        check("restart_bits", 64'(bits_since(b_e)), 64'h04332211);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
